axis_pl_to_ps: RTL and testbench
================================

# axis_pl_to_ps

PL-to-PS return path: accepts 256-bit AXI-Stream words from the PL side and serializes each into PS_AXIS_WIDTH-bit beats toward the PS (DMA S2MM). It sits downstream of the pl_clk→ps_clk `axis_async_fifo` read port, so all logic runs on ps_clk. It is the exact inverse of the PS-to-PL packer: the first PS beat carries the most-significant slice of the PL word. It generates `m_axis_tlast` on programmable packet boundaries.

## Interface
- PS_AXIS_WIDTH, 32, PS-side beat width; must divide PL_AXIS_WIDTH, ratio ≥ 2
- PL_AXIS_WIDTH, 256, PL-side word width
- ps_clk  input  1  clock for all logic
- rst  input  1  reset, asynchronous, active-low
- s_axis_tdata  input  PL_AXIS_WIDTH  PL word (from async FIFO read side)
- s_axis_tvalid  input  1  PL word valid
- s_axis_tready  output  1  block can take a PL word this cycle
- m_axis_tdata  output  PS_AXIS_WIDTH  PS beat
- m_axis_tvalid  output  1  PS beat valid
- m_axis_tready  input  1  PS sink ready
- m_axis_tlast  output  1  final beat of a packet
- pkt_len  input  16  packet length in PL words; 0 = endless stream, tlast never asserted
- busy  output  1  holding register occupied or packet in progress

## Operation
- RATIO = PL_AXIS_WIDTH / PS_AXIS_WIDTH (8 at defaults); slice counter width $clog2(RATIO).
- Holding register `hold` (PL width) + `loaded` flag + slice counter `slice` + 16-bit packet word counter `pkt_idx` + latched length `len_q`.
- Load: on s_axis_tvalid && s_axis_tready, `hold` <= s_axis_tdata, `loaded` <= 1, `slice` <= 0.
- s_axis_tready = !loaded || (slice == RATIO-1 && m_axis_tready) — back-to-back PL words with no bubble.
- m_axis_tvalid = loaded; m_axis_tdata = hold[PL-1 -: PS] (MSB slice first); on each accepted beat `hold` shifts left by PS_AXIS_WIDTH and `slice` increments.
- After beat RATIO-1 accepted: reload if new word offered same cycle, else `loaded` <= 0.
- Packet tracking: `len_q` <= pkt_len when a PL word is loaded with pkt_idx == 0; pkt_len changes mid-packet ignored.
- m_axis_tlast = loaded && slice == RATIO-1 && len_q != 0 && pkt_idx == len_q-1.
- pkt_idx increments when the last slice of a word is accepted; wraps to 0 after the tlast beat. len_q == 0: pkt_idx held at 0, no tlast.
- busy = loaded || pkt_idx != 0.
- State machine (two states): EMPTY (loaded=0) → FULL on load; FULL → FULL on last-slice accept with reload; FULL → EMPTY on last-slice accept without reload.

## Timing
- Reset values: s_axis_tready 1, m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, busy 0; hold, slice, pkt_idx, len_q cleared.
- Latency: PL word accepted at edge N → first PS beat valid after edge N (cycle N+1).
- Throughput: one PS beat per cycle with m_axis_tready held high; one PL word per RATIO cycles.
- AXIS rules: m_axis_tdata/tlast/tvalid stable while tvalid && !tready; tvalid never depends on m_axis_tready.
- m_axis_tready low on last slice: s_axis_tready low, no load that cycle.
- Reset mid-word: partial word discarded, packet count restarts at 0; no beats emitted after reset until a new load.
- pkt_len = 1: tlast on beat RATIO-1 of every word.

## Structure
- Shared package `axis_xfer_pkg`: PL_AXIS_WIDTH (256) constant and PS/PL ratio function, shared with the PS-to-PL packer.
- Single module, no sub-module; the CDC FIFO is instantiated by the parent on the pl_clk→ps_clk boundary.
- Elaboration-time check: PL_AXIS_WIDTH % PS_AXIS_WIDTH == 0 and ratio ≥ 2.

## Test plan
- Single word 0x0000_0007_..._0000_0000 (slices 7..0 from MSB), pkt_len=1, tready=1 → beats 0x7,0x6,…,0x0 on 8 consecutive cycles, tlast only on 8th, first beat one cycle after load.
- 4 back-to-back words, tready=1, pkt_len=2 → 32 contiguous beats, no bubbles, tlast on beats 16 and 32, s_axis_tready high exactly on each 8th beat.
- Random m_axis_tready (50%) with 16 words → data/tlast stable while stalled, output sequence identical to tready=1 run.
- pkt_len=0, 10 words → 80 beats, tlast never asserted, busy falls 1 cycle after final beat.
- pkt_len changed 3→1 after 1st word of packet → tlast still after word 3; next packet uses 1.
- rst asserted after beat 3 of a word → all outputs reset values next cycle; after release, new word emits from slice 0 with pkt_idx 0.

Source files
------------

// File: rtl/axis_xfer_pkg.sv
// axis_xfer_pkg
//   Shared constants and helpers for the PS<->PL AXI-Stream width
//   converters (PS-to-PL packer and PL-to-PS serializer).
//   PL_AXIS_WIDTH : native PL-side word width
//   pl_ps_ratio() : number of PS beats per PL word
//   xfer_state_e  : holding-register state used by the converters
package axis_xfer_pkg;

  localparam int PL_AXIS_WIDTH = 256;

  function automatic int pl_ps_ratio(input int pl_w, input int ps_w);
    return pl_w / ps_w;
  endfunction

  typedef enum logic {
    XFER_EMPTY = 1'b0,
    XFER_FULL  = 1'b1
  } xfer_state_e;

endpackage

// File: rtl/axis_pl_to_ps.sv
// axis_pl_to_ps
//   PL-to-PS return path. Takes one PL_AXIS_WIDTH word at a time from the
//   ps_clk read side of the CDC FIFO and emits it as RATIO beats of
//   PS_AXIS_WIDTH bits, most-significant slice first. Raises m_axis_tlast
//   on the final beat of every pkt_len-word packet (pkt_len 0 = endless).
//
// Ports
//   ps_clk, rst        : clock, asynchronous active-low reset
//   s_axis_*           : PL word input (tdata/tvalid/tready)
//   m_axis_*           : PS beat output (tdata/tvalid/tready/tlast)
//   pkt_len            : packet length in PL words, sampled at packet start
//   busy               : word held or packet partially sent
module axis_pl_to_ps #(
  parameter int PS_AXIS_WIDTH = 32,
  parameter int PL_AXIS_WIDTH = axis_xfer_pkg::PL_AXIS_WIDTH
) (
  input  logic                     ps_clk,
  input  logic                     rst,
  input  logic [PL_AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [PS_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  input  logic [15:0]              pkt_len,
  output logic                     busy
);
  import axis_xfer_pkg::*;

  localparam int RATIO = pl_ps_ratio(PL_AXIS_WIDTH, PS_AXIS_WIDTH);
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SW-1:0] LAST_SLICE = SW'(RATIO - 1);

  if ((PL_AXIS_WIDTH % PS_AXIS_WIDTH) != 0 || RATIO < 2) begin : g_param_check
    $error("axis_pl_to_ps: PS_AXIS_WIDTH must divide PL_AXIS_WIDTH with ratio >= 2");
  end

  xfer_state_e              state_q, state_d;
  logic [PL_AXIS_WIDTH-1:0] hold_q, hold_d;
  logic [SW-1:0]            slice_q, slice_d;
  logic [15:0]              pkt_idx_q, pkt_idx_d;
  logic [15:0]              len_q, len_d;

  logic loaded, last_slice, beat_acc, word_done, pkt_end, load;

  assign loaded     = (state_q == XFER_FULL);
  assign last_slice = (slice_q == LAST_SLICE);
  assign beat_acc   = loaded && m_axis_tready;
  assign word_done  = beat_acc && last_slice;
  assign pkt_end    = (len_q != 16'd0) && (pkt_idx_q == len_q - 16'd1);

  // Accept the next word in the same cycle the last slice leaves, so
  // consecutive words stream with no bubble.
  assign s_axis_tready = !loaded || (last_slice && m_axis_tready);
  assign load          = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = loaded;
  assign m_axis_tdata  = hold_q[PL_AXIS_WIDTH-1 -: PS_AXIS_WIDTH];
  assign m_axis_tlast  = loaded && last_slice && pkt_end;
  assign busy          = loaded || (pkt_idx_q != 16'd0);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    slice_d   = slice_q;
    pkt_idx_d = pkt_idx_q;
    len_d     = len_q;

    if (word_done) begin
      if (len_q == 16'd0 || pkt_end) pkt_idx_d = 16'd0;
      else                           pkt_idx_d = pkt_idx_q + 16'd1;
    end

    if (load) begin
      hold_d  = s_axis_tdata;
      slice_d = '0;
      state_d = XFER_FULL;
      // Use the post-update index: a word reloaded on the tlast beat
      // starts a new packet and must pick up the current pkt_len.
      if (pkt_idx_d == 16'd0) len_d = pkt_len;
    end else if (beat_acc) begin
      // After the final shift the register is all zero, so tdata idles at 0.
      hold_d  = hold_q << PS_AXIS_WIDTH;
      slice_d = slice_q + 1'b1;
      if (last_slice) begin
        state_d = XFER_EMPTY;
        slice_d = '0;
      end
    end
  end

  always_ff @(posedge ps_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= XFER_EMPTY;
      hold_q    <= '0;
      slice_q   <= '0;
      pkt_idx_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      slice_q   <= slice_d;
      pkt_idx_q <= pkt_idx_d;
      len_q     <= len_d;
    end
  end

endmodule

// File: tb/tb_axis_pl_to_ps.sv
module tb_axis_pl_to_ps;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic             ps_clk = 1'b0;
  logic             rst;
  logic [255:0]     s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [31:0]      m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
  logic             m_axis_tlast;
  logic [15:0]      pkt_len;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cnt  = 0;
  bit rand_mode = 1'b0;
  beat_t sb[$];
  int    pop_cyc[$];

  axis_pl_to_ps #(.PS_AXIS_WIDTH(32), .PL_AXIS_WIDTH(256)) dut (
    .ps_clk(ps_clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .pkt_len(pkt_len), .busy(busy)
  );

  always #5 ps_clk = ~ps_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sink ready: always high, or a coin toss per cycle when rand_mode is set.
  initial begin
    forever begin
      @(posedge ps_clk); #1;
      m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: everything sampled on the falling edge, mid-cycle.
  initial begin
    int          biw;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    beat_t       e;
    biw = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
    forever begin
      @(negedge ps_clk);
      cyc++;
      if (!rst) begin
        biw = 0; prev_stall = 0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stall_tdata", 64'(m_axis_tdata), 64'(prev_data));
        chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (m_axis_tvalid)
        chk("s_tready", 64'(s_axis_tready), 64'((biw == 7) && m_axis_tready));
      else
        chk("s_tready_idle", 64'(s_axis_tready), 64'd1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = sb.pop_front();
          chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
          chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
        end
        pop_cyc.push_back(cyc);
        acc_cnt++;
        biw = (biw == 7) ? 0 : biw + 1;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Word d: d[7] is the most-significant slice and therefore the first beat.
  task automatic send_word(input logic [7:0][31:0] d, input bit wlast);
    bit ok;
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.data = d[7-i];
      b.last = wlast && (i == 7);
      sb.push_back(b);
    end
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    ok = 0;
    for (int t = 0; t < 1000; t++) begin
      @(negedge ps_clk);
      if (s_axis_tready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge ps_clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 0;
    for (int t = 0; t < 2000; t++) begin
      @(posedge ps_clk); #2;
      if (sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk({name, "_drain_timeout"}, 64'(sb.size()), 64'd0);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
    chk({name, "_tvalid_after"}, 64'(m_axis_tvalid), 64'd0);
  endtask

  function automatic logic [7:0][31:0] mk(input int w);
    logic [7:0][31:0] d;
    for (int k = 0; k < 8; k++) d[k] = {8'(w), 8'(k), 16'hC0DE};
    return d;
  endfunction

  task automatic chk_reset_outputs(input string name);
    chk({name, "_s_tready"}, 64'(s_axis_tready), 64'd1);
    chk({name, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({name, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
    chk({name, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int p0, base;
    bit ok;
    rst = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; pkt_len = 16'd0;
    repeat (3) @(posedge ps_clk);
    #1 chk_reset_outputs("reset");
    rst = 1'b1;
    @(posedge ps_clk); #1;

    // Single word, slices 7..0 from MSB, one-word packets.
    pkt_len = 16'd1;
    send_word(256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000, 1'b1);
    chk("lat_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("lat_tdata", 64'(m_axis_tdata), 64'd7);
    drain("single");

    // Four back-to-back words, two-word packets: 32 beats with no gaps.
    pkt_len = 16'd2;
    p0 = pop_cyc.size();
    for (int w = 0; w < 4; w++) send_word(mk(16 + w), (w % 2) == 1);
    drain("b2b");
    if (pop_cyc.size() >= p0 + 32)
      chk("b2b_span", 64'(pop_cyc[p0+31] - pop_cyc[p0]), 64'd31);
    else
      chk("b2b_count", 64'(pop_cyc.size() - p0), 64'd32);

    // Random backpressure, four-word packets.
    rand_mode = 1'b1;
    pkt_len = 16'd4;
    for (int w = 0; w < 16; w++) send_word(mk(32 + w), (w % 4) == 3);
    drain("rand");
    rand_mode = 1'b0;

    // Endless stream: no tlast at all.
    pkt_len = 16'd0;
    p0 = acc_cnt;
    for (int w = 0; w < 10; w++) send_word(mk(64 + w), 1'b0);
    drain("endless");
    chk("endless_beats", 64'(acc_cnt - p0), 64'd80);

    // pkt_len changed mid-packet: packet of 3 keeps its length, then 1s.
    pkt_len = 16'd3;
    send_word(mk(80), 1'b0);
    pkt_len = 16'd1;
    send_word(mk(81), 1'b0);
    send_word(mk(82), 1'b1);
    send_word(mk(83), 1'b1);
    send_word(mk(84), 1'b1);
    drain("lenchg");

    // Reset after beat 3 of the second word of a two-word packet.
    pkt_len = 16'd2;
    base = acc_cnt;
    send_word(mk(96), 1'b0);
    send_word(mk(97), 1'b1);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(posedge ps_clk); #1;
      if (acc_cnt >= base + 11) begin ok = 1; break; end
    end
    if (!ok) chk("rst_wait_timeout", 64'(acc_cnt - base), 64'd11);
    rst = 1'b0;
    sb.delete();
    #1 chk_reset_outputs("midrst");
    @(posedge ps_clk); #1;
    rst = 1'b1;
    @(posedge ps_clk); #1;
    chk("post_rst_idle", 64'(m_axis_tvalid), 64'd0);
    // Packet count restarted: first word is not a packet end, second is.
    send_word(mk(112), 1'b0);
    send_word(mk(113), 1'b1);
    drain("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
